// File: rtl/quadra_seq.sv
// Sequencer for the piecewise-quadratic datapath: x -> ROM fetch -> operand regs -> y.
// Optional output clamp to [-1.0, +1.0-lsb] enabled by defining QUADRA_SEQ_SAT_EN.
module quadra_seq #(
  parameter int SEG_W   = 7,
  parameter int ROM_LAT = 1,
  localparam int X_W    = SEG_W + 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  output logic             coef_rd_en,
  output logic [SEG_W-1:0] coef_addr,
  input  logic [31:0]      coef_a,
  input  logic [31:0]      coef_b,
  input  logic [31:0]      coef_c,
  output logic [16:0]      dp_x2,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  output logic [31:0]      dp_c,
  input  logic [24:0]      dp_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_y,
  output logic             out_sat,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_EVAL, S_DONE} state_t;

  localparam logic [2:0] LAST_CNT = 3'(ROM_LAT - 1);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [16:0]        x2_q, x2_d;
  logic [SEG_W-1:0]   coef_addr_q, coef_addr_d;
  logic               coef_rd_en_q, coef_rd_en_d;
  logic [16:0]        dp_x2_q, dp_x2_d;
  logic [31:0]        dp_a_q, dp_a_d;
  logic [31:0]        dp_b_q, dp_b_d;
  logic [31:0]        dp_c_q, dp_c_d;
  logic               out_valid_q, out_valid_d;
  logic [24:0]        out_y_q, out_y_d;
  logic [24:0]        y_proc;
  logic               y_clamped;

`ifdef QUADRA_SEQ_SAT_EN
  logic out_sat_q, out_sat_d;

  always_comb begin
    y_proc    = dp_y;
    y_clamped = 1'b0;
    if ($signed(dp_y) < $signed(25'h1800000)) begin
      y_proc    = 25'h1800000;
      y_clamped = 1'b1;
    end else if ($signed(dp_y) > $signed(25'h07FFFFF)) begin
      y_proc    = 25'h07FFFFF;
      y_clamped = 1'b1;
    end
  end

  assign out_sat = out_sat_q;
`else
  assign y_proc    = dp_y;
  assign y_clamped = 1'b0;
  assign out_sat   = 1'b0;
`endif

  // In DONE the next argument may be taken on the same edge as the result handshake.
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x2_d         = x2_q;
    coef_addr_d  = coef_addr_q;
    coef_rd_en_d = 1'b0;
    dp_x2_d      = dp_x2_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_c_d       = dp_c_q;
    out_valid_d  = out_valid_q;
    out_y_d      = out_y_q;
`ifdef QUADRA_SEQ_SAT_EN
    out_sat_d    = out_sat_q;
`endif
    if (clr) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d      = S_FETCH;
            cnt_d        = 3'd0;
            coef_addr_d  = in_x[X_W-1:17];
            x2_d         = in_x[16:0];
            coef_rd_en_d = 1'b1;
          end
        end
        S_FETCH: begin
          if (cnt_q == LAST_CNT) begin
            state_d = S_CAPT;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_CAPT: begin
          dp_a_d  = coef_a;
          dp_b_d  = coef_b;
          dp_c_d  = coef_c;
          dp_x2_d = x2_q;
          state_d = S_EVAL;
        end
        S_EVAL: begin
          out_y_d     = y_proc;
`ifdef QUADRA_SEQ_SAT_EN
          out_sat_d   = y_clamped;
`endif
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (in_valid) begin
              state_d      = S_FETCH;
              cnt_d        = 3'd0;
              coef_addr_d  = in_x[X_W-1:17];
              x2_d         = in_x[16:0];
              coef_rd_en_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      x2_q         <= 17'd0;
      coef_addr_q  <= '0;
      coef_rd_en_q <= 1'b0;
      dp_x2_q      <= 17'd0;
      dp_a_q       <= 32'd0;
      dp_b_q       <= 32'd0;
      dp_c_q       <= 32'd0;
      out_valid_q  <= 1'b0;
      out_y_q      <= 25'd0;
`ifdef QUADRA_SEQ_SAT_EN
      out_sat_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x2_q         <= x2_d;
      coef_addr_q  <= coef_addr_d;
      coef_rd_en_q <= coef_rd_en_d;
      dp_x2_q      <= dp_x2_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_c_q       <= dp_c_d;
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
`ifdef QUADRA_SEQ_SAT_EN
      out_sat_q    <= out_sat_d;
`endif
    end
  end

  assign coef_rd_en = coef_rd_en_q;
  assign coef_addr  = coef_addr_q;
  assign dp_x2      = dp_x2_q;
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_c       = dp_c_q;
  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_quadra_seq.sv
// Directed bench for quadra_seq: sync ROM model (garbage outside its valid cycle) and a quadra stand-in.
module tb_quadra_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_x = 24'd0;
  logic        coef_rd_en;
  logic [6:0]  coef_addr;
  logic [31:0] coef_a, coef_b, coef_c;
  logic [16:0] dp_x2;
  logic [31:0] dp_a, dp_b, dp_c;
  logic [24:0] dp_y;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_y;
  logic        out_sat;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int rd0;

  logic [31:0] rom_a [128];
  logic [31:0] rom_b [128];
  logic [31:0] rom_c [128];

  logic [23:0] bb_arg  [3];
  logic [6:0]  bb_addr [3];
  logic [24:0] bb_exp  [3];

  always #5 clk = ~clk;

  quadra_seq dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .coef_rd_en(coef_rd_en), .coef_addr(coef_addr),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .dp_x2(dp_x2), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_y(dp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_sat(out_sat), .busy(busy)
  );

  // y = a + b*x2 + c*x2^2, a/b/c s2.30, x2 u0.17, result truncated to s2.23
  function automatic logic [24:0] quadra_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [16:0] x2);
    longint sa, sb, sc, sx, sq, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sc = longint'($signed(c));
    sx = longint'(x2);
    sq = (sx * sx) >>> 17;
    s  = sa + ((sb * sx) >>> 17) + ((sc * sq) >>> 17);
    return s[31:7];
  endfunction

  assign dp_y = quadra_model(dp_a, dp_b, dp_c, dp_x2);

  // Data is only meaningful in the single cycle after a read strobe.
  always @(posedge clk) begin
    if (coef_rd_en) begin
      coef_a <= rom_a[coef_addr];
      coef_b <= rom_b[coef_addr];
      coef_c <= rom_c[coef_addr];
      if (rst_n) rd_cnt <= rd_cnt + 1;
    end else begin
      coef_a <= 32'hDEADBEEF;
      coef_b <= 32'hBAADF00D;
      coef_c <= 32'h0BADC0DE;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      rom_a[i] = 32'd0;
      rom_b[i] = 32'd0;
      rom_c[i] = 32'd0;
    end
    rom_a[1] = 32'h1000_0000; rom_b[1] = 32'h4000_0000;  // 0.25 + 1.0*x2
    rom_a[2] = 32'h2000_0000; rom_c[2] = 32'h4000_0000;  // 0.5 + 1.0*x2^2
    rom_a[3] = 32'hF000_0000;                            // -0.25
    rom_a[4] = 32'h8000_0000;                            // -2.0
    rom_a[127] = 32'h7FFF_FFFF;                          // ~ +2.0

    bb_arg[0] = 24'h050000; bb_addr[0] = 7'd2; bb_exp[0] = 25'h0600000;
    bb_arg[1] = 24'h07FFFF; bb_addr[1] = 7'd3; bb_exp[1] = 25'h1E00000;
    bb_arg[2] = 24'h028000; bb_addr[2] = 7'd1; bb_exp[2] = 25'h0400000;

    // Reset state
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(coef_rd_en), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_dp_a", dp_a, 32'd0);

    // Single op, x1=1, x2=0.25 -> 0.25 + 0.25 = 0.5
    rd0 = rd_cnt;
    in_x = 24'h028000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_rd_en", 32'(coef_rd_en), 32'd1);
    chk("s_addr", 32'(coef_addr), 32'h01);
    chk("s_in_ready_fetch", 32'(in_ready), 32'd0);
    step();
    chk("s_rd_en_once", 32'(coef_rd_en), 32'd0);
    chk("s_ov_e2", 32'(out_valid), 32'd0);
    step();
    chk("s_dp_x2", 32'(dp_x2), 32'h08000);
    chk("s_dp_a", dp_a, 32'h1000_0000);
    chk("s_dp_b", dp_b, 32'h4000_0000);
    chk("s_ov_e3", 32'(out_valid), 32'd0);
    step();
    chk("s_ov_e4", 32'(out_valid), 32'd1);
    chk("s_out_y", 32'(out_y), 32'h0400000);
    chk("s_out_sat", 32'(out_sat), 32'd0);
    chk("s_rd_pulses", 32'(rd_cnt - rd0), 32'd1);

    // Backpressure in DONE
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_y", 32'(out_y), 32'h0400000);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rel", 32'(in_ready), 32'd1);
    step();
    chk("bp_ov_after", 32'(out_valid), 32'd0);
    chk("bp_busy_after", 32'(busy), 32'd0);
    chk("bp_addr_hold", 32'(coef_addr), 32'h01);
    chk("bp_dp_a_hold", dp_a, 32'h1000_0000);

    // Back-to-back: three args, accept on each DONE handshake edge
    in_x = bb_arg[0]; in_valid = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      in_x     = (k < 2) ? bb_arg[k+1] : 24'd0;
      in_valid = (k < 2);
      step(); step();
      chk("bb_ov_early", 32'(out_valid), 32'd0);
      step();
      chk("bb_ov", 32'(out_valid), 32'd1);
      chk("bb_y", 32'(out_y), 32'(bb_exp[k]));
      chk("bb_in_ready", 32'(in_ready), 32'd1);
      step();
      if (k < 2) begin
        chk("bb_next_busy", 32'(busy), 32'd1);
        chk("bb_next_rd_en", 32'(coef_rd_en), 32'd1);
        chk("bb_next_addr", 32'(coef_addr), 32'(bb_addr[k+1]));
        chk("bb_next_ov", 32'(out_valid), 32'd0);
      end else begin
        chk("bb_end_busy", 32'(busy), 32'd0);
      end
    end

    // clr in EVAL drops the op; next op uses fresh ROM data
    in_x = 24'h028000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_ov", 32'(out_valid), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    chk("clr_ov_later", 32'(out_valid), 32'd0);
    clr = 1'b1; in_x = 24'h050000; in_valid = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_beats_accept", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("clr_next_ov", 32'(out_valid), 32'd1);
    chk("clr_next_y", 32'(out_y), 32'h0600000);
    step();

    // Saturation boundary: x1 all-ones with a ~ +2.0, and a = -2.0
    in_x = 24'hFE0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sat_addr", 32'(coef_addr), 32'h7F);
    step(); step();
    chk("sat_dp_x2", 32'(dp_x2), 32'h00001);
    step();
    chk("sat_ov", 32'(out_valid), 32'd1);
`ifdef QUADRA_SEQ_SAT_EN
    chk("sat_hi_y", 32'(out_y), 32'h07FFFFF);
    chk("sat_hi_flag", 32'(out_sat), 32'd1);
`else
    chk("sat_hi_y", 32'(out_y), 32'h0FFFFFF);
    chk("sat_hi_flag", 32'(out_sat), 32'd0);
`endif
    step();
    in_x = 24'h080000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("sat_lo_ov", 32'(out_valid), 32'd1);
`ifdef QUADRA_SEQ_SAT_EN
    chk("sat_lo_y", 32'(out_y), 32'h1800000);
    chk("sat_lo_flag", 32'(out_sat), 32'd1);
`else
    chk("sat_lo_y", 32'(out_y), 32'h1000000);
    chk("sat_lo_flag", 32'(out_sat), 32'd0);
`endif
    step();

    // Async reset mid-FETCH
    in_x = 24'h028000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_rd_en", 32'(coef_rd_en), 32'd0);
    chk("ar_dp_a", dp_a, 32'd0);
    chk("ar_addr", 32'(coef_addr), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step(); step(); step();
    chk("ar_no_result", 32'(out_valid), 32'd0);
    chk("ar_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
